alu_share_arb: RTL and testbench
================================

// Module: alu_share_arb
// PURPOSE
//  Shares the single combinational ALU (4-bit alu_ctr op code) between two requesters,
//  e.g. the execute path (port 0) and an auxiliary address/CSR path (port 1).
//  Uses a round-robin grant, a valid/ready request handshake and a registered response
//  with backpressure. Drives the ALU operands and op code and captures the ALU result.
//  Flags op codes the ALU does not decode.
// PARAMETERS
//  XLEN   32   operand/result width in bits
// PORTS
//  clk            in   1     rising-edge clock
//  rst            in   1     synchronous, active-high reset
//  req_valid_i    in   2     [n] requester n presents an op
//  req_ready_o    out  2     [n] op of requester n accepted this cycle (valid&&ready)
//  req_ctr_i      in   8     [4n+3:4n] alu_ctr of requester n
//  req_a_i        in   2*XLEN  [XLEN*n +: XLEN] operand A of requester n
//  req_b_i        in   2*XLEN  operand B of requester n, same packing
//  alu_ctr_o      out  4     op code to ALU
//  alu_a_o        out  XLEN  operand A to ALU
//  alu_b_o        out  XLEN  operand B to ALU
//  alu_res_i      in   XLEN  ALU result (combinational from alu_*_o)
//  rsp_valid_o    out  2     [n] response for requester n valid
//  rsp_ready_i    in   2     [n] requester n consumes response
//  rsp_data_o     out  XLEN  result (shared bus; qualified by rsp_valid_o)
//  rsp_err_o      out  1     op code was illegal; qualified by rsp_valid_o
// BEHAVIOUR
//  - FSM states: IDLE -> EXEC -> RESP -> IDLE. One op is in flight at a time.
//  - IDLE:
//    - grant = the single requester with valid; if both are valid, the requester
//      indicated by rr_ptr.
//    - req_ready_o[grant]=1 combinationally; all other ready bits are 0.
//    - On accept: latch ctr/a/b/owner and go to EXEC.
//  - EXEC (1 cycle):
//    - alu_ctr_o/alu_a_o/alu_b_o = latched values.
//    - Register alu_res_i into rsp_data_o; go to RESP.
//  - RESP:
//    - rsp_valid_o[owner]=1 until rsp_ready_i[owner]=1.
//    - In that handshake cycle: go to IDLE and set rr_ptr = ~owner.
//  - Latency: accept in cycle T -> rsp_valid_o high in cycle T+2. Peak throughput is
//    1 op per 3 cycles (RESP never overlaps IDLE acceptance).
//  - Legal codes: 0000 add, 1000 sub, 0001 sll, 0010 slt, 0011 sltu, 0100 xor,
//    0101 srl, 1101 sra, 0110 or, 0111 and.
//  - Illegal code:
//    - Accepted normally and still passes through EXEC.
//    - alu_ctr_o is forced to 0000, operands to 0.
//    - rsp_data_o=0, rsp_err_o=1. rsp_err_o=0 for legal ops.
//  - Outside EXEC: alu_ctr_o=0, alu_a_o=0, alu_b_o=0 (quiet ALU inputs).
//  - A requester may drop valid before it is accepted; no state change results.
//  - rsp_ready_i of the non-owner is ignored. rsp_ready_i asserted before RESP is
//    ignored.
//  - Reset values: state=IDLE, rr_ptr=0, req_ready_o=0 during rst, rsp_valid_o=0,
//    rsp_data_o=0, rsp_err_o=0, alu_*_o=0.
//  - Reset mid-operation (EXEC or RESP): the in-flight op is discarded with no response.
//    rr_ptr returns to 0.
//  - No combinational path from rsp_ready_i to req_ready_o (a new grant only in IDLE).
// TESTING
//  1. Port 0 only, ctr=0000, a=5, b=7, rsp_ready=1
//     -> ready0 in T, alu_ctr_o=0000 in T+1, rsp_valid0 with data=12 and err=0 in T+2,
//        IDLE in T+3.
//  2. Both valid every cycle after reset, port 0 sub 10-3, port 1 sra 0x80000000>>>4
//     -> grants alternate 0,1,0; results 7 and 0xF8000000.
//  3. Port 1 ctr=1111, a=b=0xFFFFFFFF
//     -> alu_ctr_o=0 and operands 0 in EXEC; rsp_data=0, rsp_err=1.
//  4. rsp_ready0 held low 5 cycles in RESP
//     -> rsp_valid0 and rsp_data stable; req_ready both 0 throughout; accept resumes
//        the cycle after the handshake.
//  5. rst asserted during EXEC
//     -> next cycle all outputs 0, no rsp_valid; a subsequent simultaneous request is
//        granted to port 0.
//  6. slt with a=0xFFFFFFFF, b=1 -> 1; sltu same operands -> 0 (ALU passthrough).

Source files
------------

// File: rtl/alu_share_arb.sv
// Round-robin arbiter that shares one combinational ALU between two requesters.
// One op is in flight at a time; the response is registered and held until consumed.
//
// state | meaning
// IDLE  | waiting for a request; grant is offered combinationally
// EXEC  | latched op drives the ALU; result is captured at the end of the cycle
// RESP  | response held on rsp_*_o for the owner until it takes it
module alu_share_arb #(
  parameter int XLEN = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [1:0]        req_valid_i,
  output logic [1:0]        req_ready_o,
  input  logic [7:0]        req_ctr_i,
  input  logic [2*XLEN-1:0] req_a_i,
  input  logic [2*XLEN-1:0] req_b_i,
  output logic [3:0]        alu_ctr_o,
  output logic [XLEN-1:0]   alu_a_o,
  output logic [XLEN-1:0]   alu_b_o,
  input  logic [XLEN-1:0]   alu_res_i,
  output logic [1:0]        rsp_valid_o,
  input  logic [1:0]        rsp_ready_i,
  output logic [XLEN-1:0]   rsp_data_o,
  output logic              rsp_err_o
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t            state;
  logic              rr_ptr;
  logic              owner;
  logic              illegal_q;
  logic              grant;
  logic              sel_legal;
  logic [3:0]        sel_ctr;
  logic [XLEN-1:0]   sel_a;
  logic [XLEN-1:0]   sel_b;

  always_comb begin
    grant = (req_valid_i == 2'b11) ? rr_ptr : req_valid_i[1];
    sel_ctr = grant ? req_ctr_i[7:4] : req_ctr_i[3:0];
    sel_a   = grant ? req_a_i[2*XLEN-1:XLEN] : req_a_i[XLEN-1:0];
    sel_b   = grant ? req_b_i[2*XLEN-1:XLEN] : req_b_i[XLEN-1:0];
    case (sel_ctr)
      4'b0000, 4'b1000, 4'b0001, 4'b0010, 4'b0011,
      4'b0100, 4'b0101, 4'b1101, 4'b0110, 4'b0111: sel_legal = 1'b1;
      default:                                      sel_legal = 1'b0;
    endcase
    // ready depends only on state and request valid, never on rsp_ready_i
    req_ready_o = 2'b00;
    if (state == IDLE && !rst && (|req_valid_i))
      req_ready_o[grant] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      rr_ptr      <= 1'b0;
      owner       <= 1'b0;
      illegal_q   <= 1'b0;
      alu_ctr_o   <= '0;
      alu_a_o     <= '0;
      alu_b_o     <= '0;
      rsp_valid_o <= 2'b00;
      rsp_data_o  <= '0;
      rsp_err_o   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (|req_valid_i) begin
            owner     <= grant;
            illegal_q <= !sel_legal;
            // illegal ops still run through EXEC, but with a quiet ALU
            alu_ctr_o <= sel_legal ? sel_ctr : 4'b0000;
            alu_a_o   <= sel_legal ? sel_a : '0;
            alu_b_o   <= sel_legal ? sel_b : '0;
            state     <= EXEC;
          end
        end
        EXEC: begin
          rsp_data_o  <= illegal_q ? '0 : alu_res_i;
          rsp_err_o   <= illegal_q;
          rsp_valid_o <= owner ? 2'b10 : 2'b01;
          alu_ctr_o   <= '0;
          alu_a_o     <= '0;
          alu_b_o     <= '0;
          state       <= RESP;
        end
        RESP: begin
          if (rsp_ready_i[owner]) begin
            rsp_valid_o <= 2'b00;
            rr_ptr      <= ~owner;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_share_arb.sv
// Directed bench for alu_share_arb: a behavioural ALU closes the loop and every
// expected value below is a hand-computed constant.
module tb_alu_share_arb;
  localparam int XLEN = 32;

  logic              clk = 1'b0;
  logic              rst;
  logic [1:0]        req_valid_i;
  logic [1:0]        req_ready_o;
  logic [7:0]        req_ctr_i;
  logic [2*XLEN-1:0] req_a_i;
  logic [2*XLEN-1:0] req_b_i;
  logic [3:0]        alu_ctr_o;
  logic [XLEN-1:0]   alu_a_o;
  logic [XLEN-1:0]   alu_b_o;
  logic [XLEN-1:0]   alu_res_i;
  logic [1:0]        rsp_valid_o;
  logic [1:0]        rsp_ready_i;
  logic [XLEN-1:0]   rsp_data_o;
  logic              rsp_err_o;

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  alu_share_arb #(.XLEN(XLEN)) dut (
    .clk(clk), .rst(rst),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
    .req_ctr_i(req_ctr_i), .req_a_i(req_a_i), .req_b_i(req_b_i),
    .alu_ctr_o(alu_ctr_o), .alu_a_o(alu_a_o), .alu_b_o(alu_b_o),
    .alu_res_i(alu_res_i),
    .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i),
    .rsp_data_o(rsp_data_o), .rsp_err_o(rsp_err_o)
  );

  always_comb begin
    case (alu_ctr_o)
      4'b0000: alu_res_i = alu_a_o + alu_b_o;
      4'b1000: alu_res_i = alu_a_o - alu_b_o;
      4'b0001: alu_res_i = alu_a_o << alu_b_o[4:0];
      4'b0010: alu_res_i = {31'd0, $signed(alu_a_o) < $signed(alu_b_o)};
      4'b0011: alu_res_i = {31'd0, alu_a_o < alu_b_o};
      4'b0100: alu_res_i = alu_a_o ^ alu_b_o;
      4'b0101: alu_res_i = alu_a_o >> alu_b_o[4:0];
      4'b1101: alu_res_i = $unsigned($signed(alu_a_o) >>> alu_b_o[4:0]);
      4'b0110: alu_res_i = alu_a_o | alu_b_o;
      4'b0111: alu_res_i = alu_a_o & alu_b_o;
      default: alu_res_i = 32'hDEAD_BEEF;
    endcase
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // advance to just after the next rising edge; inputs are driven here
  task automatic next();
    @(posedge clk);
    #2;
  endtask

  task automatic set_req(input int port, input logic [3:0] ctr,
                         input logic [31:0] a, input logic [31:0] b);
    if (port == 0) begin
      req_ctr_i[3:0] = ctr; req_a_i[31:0] = a; req_b_i[31:0] = b;
    end else begin
      req_ctr_i[7:4] = ctr; req_a_i[63:32] = a; req_b_i[63:32] = b;
    end
  endtask

  initial begin
    rst = 1'b1; req_valid_i = 2'b11; rsp_ready_i = 2'b00;
    req_ctr_i = '0; req_a_i = '0; req_b_i = '0;
    next(); next();
    #1;
    chk("rst_ready", req_ready_o, 2'b00);
    chk("rst_rsp_valid", rsp_valid_o, 2'b00);
    chk("rst_data", rsp_data_o, 0);
    chk("rst_err", rsp_err_o, 0);
    chk("rst_alu", {alu_ctr_o, alu_a_o, alu_b_o}, 0);
    rst = 1'b0; req_valid_i = 2'b00;

    // 1: port 0 add 5+7
    next();
    set_req(0, 4'b0000, 32'd5, 32'd7); req_valid_i = 2'b01; rsp_ready_i = 2'b01;
    #1;
    chk("t1_ready", req_ready_o, 2'b01);
    chk("t1_idle_alu_a", alu_a_o, 0);
    next(); req_valid_i = 2'b00; #1;
    chk("t1_exec_alu", {alu_ctr_o, alu_a_o, alu_b_o}, {4'b0000, 32'd5, 32'd7});
    chk("t1_exec_ready", req_ready_o, 2'b00);
    chk("t1_exec_rsp_valid", rsp_valid_o, 2'b00);
    next(); #1;
    chk("t1_rsp", {rsp_valid_o, rsp_err_o, rsp_data_o}, {2'b01, 1'b0, 32'd12});
    chk("t1_resp_alu_quiet", alu_ctr_o, 0);
    next(); req_valid_i = 2'b10; #1;
    chk("t1_back_idle", {rsp_valid_o, req_ready_o}, {2'b00, 2'b10});
    req_valid_i = 2'b00;   // dropped before acceptance
    next(); req_valid_i = 2'b01; #1;
    chk("t1_drop_no_change", req_ready_o, 2'b01);
    req_valid_i = 2'b00;

    // 2: both valid after reset, grants 0,1,0
    rst = 1'b1; next(); rst = 1'b0;
    set_req(0, 4'b1000, 32'd10, 32'd3);
    set_req(1, 4'b1101, 32'h8000_0000, 32'd4);
    req_valid_i = 2'b11; rsp_ready_i = 2'b11; #1;
    chk("t2_grant0", req_ready_o, 2'b01);
    next(); #1;
    chk("t2_exec0_ctr", alu_ctr_o, 4'b1000);
    next(); #1;
    chk("t2_rsp0", {rsp_valid_o, rsp_err_o, rsp_data_o}, {2'b01, 1'b0, 32'd7});
    next(); #1;
    chk("t2_grant1", req_ready_o, 2'b10);
    next(); #1;
    chk("t2_exec1", {alu_ctr_o, alu_a_o, alu_b_o}, {4'b1101, 32'h8000_0000, 32'd4});
    next(); #1;
    chk("t2_rsp1", {rsp_valid_o, rsp_err_o, rsp_data_o}, {2'b10, 1'b0, 32'hF800_0000});
    next(); #1;
    chk("t2_grant0_again", req_ready_o, 2'b01);
    req_valid_i = 2'b00;

    // 3: illegal op on port 1
    next();
    set_req(1, 4'b1111, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    req_valid_i = 2'b10; rsp_ready_i = 2'b10; #1;
    chk("t3_ready", req_ready_o, 2'b10);
    next(); req_valid_i = 2'b00; #1;
    chk("t3_exec_quiet", {alu_ctr_o, alu_a_o, alu_b_o}, 0);
    next(); #1;
    chk("t3_rsp", {rsp_valid_o, rsp_err_o, rsp_data_o}, {2'b10, 1'b1, 32'd0});
    next(); #1;
    chk("t3_idle", rsp_valid_o, 2'b00);

    // 4: backpressure on port 0 for 5 cycles, port 1 waiting
    set_req(0, 4'b0000, 32'd1, 32'd2);
    set_req(1, 4'b0110, 32'hF0, 32'h0F);
    req_valid_i = 2'b11; rsp_ready_i = 2'b00; #1;
    chk("t4_grant0", req_ready_o, 2'b01);
    next(); #1;
    chk("t4_exec_ready", req_ready_o, 2'b00);
    for (int i = 0; i < 5; i++) begin
      next();
      rsp_ready_i = (i % 2 == 1) ? 2'b10 : 2'b00;
      #1;
      chk("t4_hold", {req_ready_o, rsp_valid_o, rsp_err_o, rsp_data_o},
          {2'b00, 2'b01, 1'b0, 32'd3});
    end
    next(); rsp_ready_i = 2'b01; #1;
    chk("t4_handshake", {req_ready_o, rsp_valid_o}, {2'b00, 2'b01});
    next(); #1;
    chk("t4_resume", {req_ready_o, rsp_valid_o}, {2'b10, 2'b00});
    req_valid_i = 2'b00;

    // 5: reset during EXEC (rr_ptr is 1 beforehand)
    next();
    set_req(0, 4'b0100, 32'hAA, 32'h55);
    req_valid_i = 2'b01; rsp_ready_i = 2'b01;
    next(); req_valid_i = 2'b00; #1;
    chk("t5_exec", alu_a_o, 32'hAA);
    rst = 1'b1;
    next(); #1;
    chk("t5_flush", {req_ready_o, rsp_valid_o, rsp_err_o, rsp_data_o, alu_ctr_o, alu_a_o, alu_b_o}, 0);
    rst = 1'b0; req_valid_i = 2'b11; #1;
    chk("t5_grant0", req_ready_o, 2'b01);
    req_valid_i = 2'b00;
    next(); #1;
    chk("t5_no_rsp", rsp_valid_o, 2'b00);

    // 6: slt / sltu passthrough on port 0
    set_req(0, 4'b0010, 32'hFFFF_FFFF, 32'd1);
    req_valid_i = 2'b01; rsp_ready_i = 2'b01;
    next(); req_valid_i = 2'b00;
    next(); #1;
    chk("t6_slt", {rsp_valid_o, rsp_err_o, rsp_data_o}, {2'b01, 1'b0, 32'd1});
    next();
    set_req(0, 4'b0011, 32'hFFFF_FFFF, 32'd1);
    req_valid_i = 2'b01;
    next(); req_valid_i = 2'b00;
    next(); #1;
    chk("t6_sltu", {rsp_valid_o, rsp_err_o, rsp_data_o}, {2'b01, 1'b0, 32'd0});
    next();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
